flux_rr_drain: RTL and testbench
================================

Name: flux_rr_drain

Overview:
- Downstream consumer of the multi-flux tagged FIFO (per-flux `empty`, one-hot `rd`, single registered `dataout`).
- Selects a non-empty flux round-robin and pulses the matching `rd` bit.
- Captures the FIFO `dataout` on the following cycle, strips the tag and presents payload plus flux index on a valid/ready stream.
- Credit-based issue against a small output buffer, so FIFO reads never outrun downstream backpressure.

Parameters:
- `WIDTH`, 8: FIFO word width, tag included.
- `FLUX`, 2: number of fluxes; must be ≥ 2.
- `TAG_WIDTH`, `$clog2(FLUX)`: tag field, `datain[WIDTH-1 -: TAG_WIDTH]`.
- `OBUF_DEPTH`, 3: output buffer entries; must be ≥ 2. A value of 3 gives one word per cycle sustained.

Ports:
- `ck`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low. The parent inverts it for the FIFO's active-high reset.
- `fifo_empty`  in  FLUX: per-flux empty from the FIFO.
- `fifo_dataout`  in  WIDTH: FIFO read data; valid the cycle after `rd`.
- `fifo_rd`  out  FLUX: one-hot (or zero) read strobe to the FIFO.
- `out_data`  out  WIDTH-TAG_WIDTH: payload with the tag removed.
- `out_flux`  out  TAG_WIDTH: source flux index.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: downstream accept.
- `tag_err`  out  1: sticky; set when a captured tag ≠ issued flux.

Behaviour:
- **Reset values** (`rst`=0, asynchronous): `fifo_rd`=0, `out_valid`=0, `out_data`=0, `out_flux`=0, `tag_err`=0, `rr_ptr`=FLUX-1 (flux 0 wins first), `infl_vld`=0, `occ`=0.
- **Issue condition**, cycle t:
  - `credit_ok = (occ + infl_vld) < OBUF_DEPTH`, using registered values only; there is no combinational path from `out_ready` to `fifo_rd`.
  - `req = ~fifo_empty`.
  - If `credit_ok` and `req`≠0: grant the first set bit of `req` searching `rr_ptr+1, rr_ptr+2, …` modulo FLUX (wrap FLUX-1 → 0).
  - `fifo_rd` = one-hot(grant), combinational; at most one bit set, ever.
- **Edge ending cycle t** (a read was issued):
  - `rr_ptr`←grant.
  - `infl_vld`←1, `infl_id`←grant.
  - If no read was issued: `infl_vld`←0 and `rr_ptr` holds.
- **Capture**, cycle t+1 with `infl_vld`=1:
  - Push `{infl_id, fifo_dataout[WIDTH-TAG_WIDTH-1:0]}` into the output buffer at the end-of-cycle edge.
  - If `fifo_dataout[WIDTH-1 -: TAG_WIDTH]` ≠ `infl_id`, set `tag_err` (cleared only by reset). The word is still forwarded.
- **Latency**: `fifo_rd` in cycle t → `out_valid` in cycle t+2 when the buffer is empty.
- **Output buffer**: FIFO of `OBUF_DEPTH` entries.
  - `out_*` come from the head entry; `out_valid` = (`occ`≠0).
  - Pop on `out_valid & out_ready`.
  - `out_data` and `out_flux` stay stable while `out_valid` is high and `out_ready` is low.
- **Occupancy**: `occ` next = `occ` + push − pop; a simultaneous push and pop leaves `occ` unchanged. The credit rule guarantees a push never finds the buffer full; an assertion flags a push when `occ`==OBUF_DEPTH.
- **Throughput**: with `out_ready` held at 1 and at least one non-empty flux, one `fifo_rd` per cycle sustained (`OBUF_DEPTH`=3).
- **Fairness**: a flux that stays non-empty is granted within FLUX consecutive issues.
- **Single flux active**: granted every cycle the credit allows.
- **All empty**: `fifo_rd`=0; `rr_ptr` and the buffer are unchanged, and the buffer drains normally.
- **Empty update timing**: the FIFO's `empty` reflects a pop on the cycle after `rd`, so back-to-back reads of the same flux are legal. The FIFO ignores `rd` on an empty flux; this block never issues one.
- **Reset mid-operation**: the in-flight read and all buffered words are discarded. The FIFO is reset by the same event, so there is no orphan data.

Decomposition:
- **Shared package** `flux_pkg`:
  - `TAG_WIDTH` derivation function.
  - Flux index typedef.
  - Round-robin priority function (request vector, pointer → one-hot grant), reused by later multi-flux blocks.
- **Sub-module** `flux_obuf`: parameterised `OBUF_DEPTH` register FIFO (push, pop, head, `occ`), instanced once.
- **Top level**: arbiter, in-flight register, tag check.

Test Plan:
- **Single word**: after reset, FLUX=2, `fifo_empty`=2'b10, `out_ready`=1, FIFO returns 8'h05 (tag 0) → `fifo_rd`=2'b01 for one cycle, then `out_valid`=1 two cycles later with `out_data`=7'h05, `out_flux`=0, `tag_err`=0.
- **Round-robin**: both fluxes non-empty with 4 words each, `out_ready`=1 → `fifo_rd` sequence 01,10,01,10,01,10,01,10 on consecutive cycles; `out_flux` sequence 0,1,0,1,…
- **Backpressure**: one flux holds 10 words, `out_ready`=0 → exactly 3 `fifo_rd` pulses, then `fifo_rd`=0 and `out_data` stable. Release `out_ready` → all 10 words delivered in order with no loss or duplicate.
- **Simultaneous push/pop**: buffer occupancy 2, `out_ready`=1, read issued → `occ` stays 2 and output order is preserved.
- **Tag mismatch**: FIFO returns 8'h85 (tag 1) for a flux-0 read → `tag_err`=1 next cycle and stays 1 until reset; word still delivered with `out_flux`=0.
- **Reset mid-stream**: assert `rst`=0 while `occ`=2 and a read is in flight → `out_valid`, `fifo_rd` and `tag_err` go 0 immediately. After release, the first grant goes to flux 0.

Source files
------------

// File: rtl/flux_pkg.sv
// Shared definitions for the multi-flux blocks: tag width derivation,
// flux index/vector types and the round-robin priority function.
package flux_pkg;

    // Widest flux count any multi-flux block is expected to use.
    localparam int MAX_FLUX = 32;

    typedef logic [MAX_FLUX-1:0]         flux_vec_t;
    typedef logic [$clog2(MAX_FLUX)-1:0] flux_idx_t;

    // Width of the tag field that carries a flux index (at least one bit).
    function automatic int tag_width(input int flux);
        return (flux <= 1) ? 1 : $clog2(flux);
    endfunction

    // One-hot grant of the first set request after ptr, searching
    // ptr+1, ptr+2, ... modulo flux. Returns zero when nothing is requested.
    function automatic flux_vec_t rr_grant(input flux_vec_t req,
                                           input flux_idx_t ptr,
                                           input int        flux);
        flux_vec_t g;
        logic      found;
        flux_idx_t idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_FLUX; i++) begin
            if (i <= flux && !found) begin
                idx = flux_idx_t'((int'(ptr) + i) % flux);
                if (req[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/flux_obuf.sv
// Small register FIFO holding captured words until the downstream accepts
// them. The head entry is presented combinationally from storage.
module flux_obuf
    import flux_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 3,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [OCC_W-1:0] occ
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; push and pop may happen together.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // The issuing side's credit scheme must never let a push hit a full buffer.
    a_no_overflow: assert property (@(posedge ck) disable iff (!rst)
        push |-> (occ != OCC_W'(DEPTH)));

endmodule

// File: rtl/flux_rr_drain.sv
// Drains a multi-flux tagged FIFO: round-robin read issue under output
// buffer credit, capture of the read data one cycle later, tag strip/check
// and delivery on a valid/ready stream.
//
// Output handshake: a word transfers on every rising edge where out_valid
// and out_ready are both high. out_valid never depends on out_ready, and
// out_data/out_flux hold steady while out_valid is high and out_ready low.
module flux_rr_drain
    import flux_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int FLUX       = 2,
    parameter int TAG_WIDTH  = tag_width(FLUX),
    parameter int OBUF_DEPTH = 3
) (
    input  logic                   ck,
    input  logic                   rst,
    input  logic [FLUX-1:0]        fifo_empty,
    input  logic [WIDTH-1:0]       fifo_dataout,
    output logic [FLUX-1:0]        fifo_rd,
    output logic [WIDTH-TAG_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]   out_flux,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   tag_err
);

    localparam int PW    = WIDTH - TAG_WIDTH;
    localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [TAG_WIDTH-1:0] infl_id;
    logic                 infl_vld;
    logic [TAG_WIDTH-1:0] grant_idx;
    logic [FLUX-1:0]      grant;
    logic [OCC_W-1:0]     occ;
    logic [WIDTH-1:0]     head;
    logic                 credit_ok;
    logic                 issue;
    logic                 pop;

    // Words already owed to the buffer (queued plus in flight) bound the issue.
    assign credit_ok = (int'(occ) + int'(infl_vld)) < OBUF_DEPTH;

    // Round-robin choice among non-empty fluxes, starting after the last grant.
    always_comb begin
        grant = FLUX'(rr_grant(flux_vec_t'(~fifo_empty), flux_idx_t'(rr_ptr), FLUX));
    end

    // One-hot grant to index for the pointer and in-flight tag.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (grant[i]) grant_idx = TAG_WIDTH'(i);
        end
    end

    // Reset also silences the strobe so a resetting FIFO sees no read.
    assign issue   = rst && credit_ok && (grant != '0);
    assign fifo_rd = issue ? grant : '0;

    // Arbiter pointer and in-flight read tracking.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= TAG_WIDTH'(FLUX - 1);
            infl_vld <= 1'b0;
            infl_id  <= '0;
        end else begin
            infl_vld <= issue;
            if (issue) begin
                rr_ptr  <= grant_idx;
                infl_id <= grant_idx;
            end
        end
    end

    // Sticky flag for read data whose tag disagrees with the flux we read.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            tag_err <= 1'b0;
        end else if (infl_vld && (fifo_dataout[WIDTH-1 -: TAG_WIDTH] != infl_id)) begin
            tag_err <= 1'b1;
        end
    end

    assign pop = out_valid & out_ready;

    flux_obuf #(
        .W     (WIDTH),
        .DEPTH (OBUF_DEPTH),
        .OCC_W (OCC_W)
    ) u_obuf (
        .ck        (ck),
        .rst       (rst),
        .push      (infl_vld),
        .push_data ({infl_id, fifo_dataout[PW-1:0]}),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign out_valid = (occ != '0);
    assign out_flux  = head[WIDTH-1 -: TAG_WIDTH];
    assign out_data  = head[PW-1:0];

endmodule

// File: tb/tb_flux_rr_drain.sv
// Bench for flux_rr_drain: a queue-based model of the tagged FIFO feeds the
// design, and a reference model predicts every read strobe and output word.
module tb_flux_rr_drain;

    localparam int WIDTH = 8;
    localparam int FLUX  = 2;
    localparam int TW    = 1;
    localparam int PW    = WIDTH - TW;
    localparam int DEPTH = 3;

    logic             ck = 1'b0;
    logic             rst = 1'b0;
    logic [FLUX-1:0]  fifo_empty;
    logic [WIDTH-1:0] fifo_dataout;
    logic [FLUX-1:0]  fifo_rd;
    logic [PW-1:0]    out_data;
    logic [TW-1:0]    out_flux;
    logic             out_valid;
    logic             out_ready;
    logic             tag_err;

    flux_rr_drain #(
        .WIDTH(WIDTH), .FLUX(FLUX), .OBUF_DEPTH(DEPTH)
    ) u_dut (
        .ck(ck), .rst(rst), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
        .fifo_rd(fifo_rd), .out_data(out_data), .out_flux(out_flux),
        .out_valid(out_valid), .out_ready(out_ready), .tag_err(tag_err)
    );

    // ---------------- clock / reset ----------------
    always #5 ck = ~ck;

    // ---------------- models ----------------
    logic [WIDTH-1:0] fq0[$];      // upstream FIFO contents, flux 0
    logic [WIDTH-1:0] fq1[$];      // upstream FIFO contents, flux 1
    logic [WIDTH-1:0] exp_q[$];    // words expected in the output buffer {flux, payload}
    logic             infl_m;
    logic [WIDTH-1:0] infl_word;
    logic [WIDTH-1:0] infl_raw;
    int               last_grant;
    logic             tag_err_m;
    int               total = 0;
    int               bad = 0;

    function automatic int next_grant(input logic [FLUX-1:0] req, input int last);
        for (int i = 1; i <= FLUX; i++) begin
            int c;
            c = (last + i) % FLUX;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic update_empty();
        fifo_empty = {fq1.size() == 0, fq0.size() == 0};
    endtask

    task automatic load_done();
        update_empty();
        #1;
    endtask

    task automatic model_clear();
        fq0.delete();
        fq1.delete();
        exp_q.delete();
        infl_m       = 1'b0;
        infl_word    = '0;
        infl_raw     = '0;
        last_grant   = FLUX - 1;
        tag_err_m    = 1'b0;
        fifo_dataout = '0;
        update_empty();
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(negedge ck);
        rst = 1'b1;
        #1;
    endtask

    // One clock: predict and compare this cycle, then advance FIFO and models.
    task automatic step();
        logic [FLUX-1:0] req, exp_rd, rd_seen;
        int              g;
        bit              acc;
        req    = ~fifo_empty;
        exp_rd = '0;
        g      = -1;
        if (exp_q.size() + int'(infl_m) < DEPTH && req != '0) begin
            g = next_grant(req, last_grant);
            exp_rd[g] = 1'b1;
        end
        total++;
        if (fifo_rd !== exp_rd) begin
            bad++;
            $display("FAIL rd_issue: fifo_rd=%b expected=%b", fifo_rd, exp_rd);
        end
        total++;
        if (out_valid !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL out_valid: got=%b expected=%b", out_valid, exp_q.size() != 0);
        end
        if (exp_q.size() != 0) begin
            total++;
            if ({out_flux, out_data} !== exp_q[0]) begin
                bad++;
                $display("FAIL out_word: got flux=%0d data=%h expected flux=%0d data=%h",
                         out_flux, out_data, exp_q[0][WIDTH-1], exp_q[0][PW-1:0]);
            end
        end
        total++;
        if (tag_err !== tag_err_m) begin
            bad++;
            $display("FAIL tag_err: got=%b expected=%b", tag_err, tag_err_m);
        end
        acc     = (exp_q.size() != 0) && out_ready;
        rd_seen = fifo_rd;
        @(posedge ck);
        #1;
        if (acc) void'(exp_q.pop_front());
        if (infl_m) begin
            exp_q.push_back(infl_word);
            if (infl_raw[WIDTH-1 -: TW] != infl_word[WIDTH-1 -: TW]) tag_err_m = 1'b1;
        end
        infl_m = (g >= 0);
        if (g >= 0) begin
            infl_raw   = (g == 0) ? fq0[0] : fq1[0];
            infl_word  = {TW'(g), infl_raw[PW-1:0]};
            last_grant = g;
        end
        if (rd_seen[0] && fq0.size() > 0)      fifo_dataout = fq0.pop_front();
        else if (rd_seen[1] && fq1.size() > 0) fifo_dataout = fq1.pop_front();
        update_empty();
        @(negedge ck);
    endtask

    function automatic logic [WIDTH-1:0] mk_word(input int flux, input int payload);
        return {TW'(flux), PW'(payload)};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        model_clear();
        fq0.push_back(mk_word(0, 1));
        fq1.push_back(mk_word(1, 2));
        load_done();
        total++;
        if (fifo_rd !== '0) begin bad++; $display("FAIL reset_rd: got=%b expected=00", fifo_rd); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b expected=0", out_valid); end
        total++;
        if (out_data !== '0 || out_flux !== '0) begin
            bad++; $display("FAIL reset_out: data=%h flux=%0d expected 0", out_data, out_flux);
        end
        total++;
        if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err: got=%b expected=0", tag_err); end
    endtask

    task automatic test_single_word();
        apply_reset();
        fq0.push_back(8'h05);
        load_done();
        total++;
        if (fifo_rd !== 2'b01) begin bad++; $display("FAIL single_rd: got=%b expected=01", fifo_rd); end
        step();
        total++;
        if (fifo_rd !== 2'b00 || out_valid !== 1'b0) begin
            bad++; $display("FAIL single_gap: rd=%b valid=%b expected 00/0", fifo_rd, out_valid);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 7'h05 || out_flux !== 1'b0 || tag_err !== 1'b0) begin
            bad++;
            $display("FAIL single_out: valid=%b data=%h flux=%0d tag_err=%b expected 1/05/0/0",
                     out_valid, out_data, out_flux, tag_err);
        end
        repeat (2) step();
    endtask

    task automatic test_round_robin();
        logic [FLUX-1:0] rd_exp;
        int              flux_seen;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            fq0.push_back(mk_word(0, 8'h10 + i));
            fq1.push_back(mk_word(1, 8'h20 + i));
        end
        load_done();
        flux_seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                rd_exp = (c % 2 == 0) ? 2'b01 : 2'b10;
                total++;
                if (fifo_rd !== rd_exp) begin
                    bad++; $display("FAIL rr_seq[%0d]: got=%b expected=%b", c, fifo_rd, rd_exp);
                end
            end
            if (out_valid === 1'b1) begin
                total++;
                if (out_flux !== TW'(flux_seen % 2)) begin
                    bad++; $display("FAIL rr_flux[%0d]: got=%0d expected=%0d", flux_seen, out_flux, flux_seen % 2);
                end
                flux_seen++;
            end
            step();
        end
        total++;
        if (flux_seen != 8) begin bad++; $display("FAIL rr_count: got=%0d expected=8", flux_seen); end
    endtask

    task automatic test_backpressure();
        int          pulses;
        int          delivered;
        logic [PW-1:0] held;
        apply_reset();
        for (int i = 0; i < 10; i++) fq0.push_back(mk_word(0, 8'h30 + i));
        out_ready = 1'b0;
        load_done();
        pulses = 0;
        held = '0;
        for (int c = 0; c < 8; c++) begin
            if (fifo_rd != '0) pulses++;
            if (c == 3) held = out_data;
            if (c > 3) begin
                total++;
                if (out_data !== held) begin
                    bad++; $display("FAIL bp_stable: got=%h expected=%h", out_data, held);
                end
            end
            step();
        end
        total++;
        if (pulses != 3) begin bad++; $display("FAIL bp_pulses: got=%0d expected=3", pulses); end
        out_ready = 1'b1;
        delivered = 0;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || infl_m || fq0.size() != 0); c++) begin
            if (out_valid === 1'b1) delivered++;
            step();
        end
        total++;
        if (delivered != 10) begin bad++; $display("FAIL bp_delivered: got=%0d expected=10", delivered); end
    endtask

    task automatic test_push_pop();
        apply_reset();
        for (int i = 0; i < 6; i++) fq0.push_back(mk_word(0, 8'h40 + i));
        out_ready = 1'b0;
        load_done();
        repeat (3) step();
        total++;
        if (u_dut.occ !== 2'd2) begin bad++; $display("FAIL pp_occ_before: got=%0d expected=2", u_dut.occ); end
        out_ready = 1'b1;
        step();
        total++;
        if (u_dut.occ !== 2'd2) begin bad++; $display("FAIL pp_occ_after: got=%0d expected=2", u_dut.occ); end
        for (int c = 0; c < 20 && (exp_q.size() != 0 || infl_m || fq0.size() != 0); c++) step();
    endtask

    task automatic test_tag_mismatch();
        apply_reset();
        fq0.push_back(8'h85);
        fq1.push_back(mk_word(1, 8'h11));
        load_done();
        step();
        step();
        total++;
        if (tag_err !== 1'b1) begin bad++; $display("FAIL tm_set: got=%b expected=1", tag_err); end
        total++;
        if (out_valid !== 1'b1 || out_flux !== 1'b0 || out_data !== 7'h05) begin
            bad++; $display("FAIL tm_word: valid=%b flux=%0d data=%h expected 1/0/05", out_valid, out_flux, out_data);
        end
        repeat (4) step();
        total++;
        if (tag_err !== 1'b1) begin bad++; $display("FAIL tm_sticky: got=%b expected=1", tag_err); end
    endtask

    task automatic test_random_stream();
        int f;
        apply_reset();
        load_done();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                f = $urandom_range(0, FLUX - 1);
                if (f == 0) fq0.push_back(mk_word(0, $urandom_range(0, 127)));
                else        fq1.push_back(mk_word(1, $urandom_range(0, 127)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            load_done();
            step();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && (exp_q.size() != 0 || infl_m || fq0.size() != 0 || fq1.size() != 0); c++) step();
        total++;
        if (exp_q.size() != 0 || fq0.size() != 0 || fq1.size() != 0) begin
            bad++; $display("FAIL rand_drain: words left buffer=%0d fifo=%0d", exp_q.size(), fq0.size() + fq1.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        fq0.push_back(8'h85);
        for (int i = 0; i < 6; i++) fq0.push_back(mk_word(0, 8'h50 + i));
        fq1.push_back(mk_word(1, 8'h60));
        out_ready = 1'b0;
        load_done();
        repeat (3) step();
        total++;
        if (out_valid !== 1'b1 || tag_err !== 1'b1) begin
            bad++; $display("FAIL mid_pre: valid=%b tag_err=%b expected 1/1", out_valid, tag_err);
        end
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || fifo_rd !== '0 || tag_err !== 1'b0) begin
            bad++; $display("FAIL mid_reset: valid=%b rd=%b tag_err=%b expected 0/00/0", out_valid, fifo_rd, tag_err);
        end
        model_clear();
        repeat (2) @(negedge ck);
        rst = 1'b1;
        out_ready = 1'b1;
        fq0.push_back(mk_word(0, 8'h70));
        fq1.push_back(mk_word(1, 8'h71));
        load_done();
        total++;
        if (fifo_rd !== 2'b01) begin bad++; $display("FAIL mid_first_grant: got=%b expected=01", fifo_rd); end
        repeat (6) step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        out_ready = 1'b1;
        model_clear();
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_tag_mismatch();
        test_random_stream();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
